// File: rtl/ssd_capture_decoder.sv
// Receive-side decoder for a two-digit multiplexed seven-segment bus: filters,
// decodes and reassembles the displayed byte, flagging illegal codes.
module ssd_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 1
) (
    input  logic       ssd_clk,
    input  logic       ssd_rst,
    input  logic [6:0] ssd_dec_port_cc,
    input  logic [7:0] ssd_dec_port_an,
    output logic [7:0] ssd_dec_port_out,
    output logic       ssd_dec_port_valid,
    output logic       ssd_dec_port_chg,
    output logic       ssd_dec_port_err,
    output logic [7:0] ssd_dec_port_err_cnt
);
    typedef enum logic [1:0] {IDLE, GOT_LO, GOT_HI} state_t;

    localparam logic [3:0] STABLE_W = 4'(STABLE_CYCLES);

    state_t     r_state, w_next;
    logic [6:0] r_cc;
    logic [7:0] r_an;
    logic [3:0] r_cnt;
    logic       r_done;
    logic [3:0] r_lo, r_hi;

    logic       w_same, w_accept, w_seg_ok, w_is_lo, w_is_hi, w_blank;
    logic       w_lo_ev, w_hi_ev, w_err_ev, w_complete;
    logic [3:0] w_nib;
    logic [7:0] w_byte;

    // Active-low pattern -> {legal, nibble}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40: seg_decode = 5'h10;  7'h79: seg_decode = 5'h11;
            7'h24: seg_decode = 5'h12;  7'h30: seg_decode = 5'h13;
            7'h19: seg_decode = 5'h14;  7'h12: seg_decode = 5'h15;
            7'h02: seg_decode = 5'h16;  7'h78: seg_decode = 5'h17;
            7'h00: seg_decode = 5'h18;  7'h18: seg_decode = 5'h19;
            7'h08: seg_decode = 5'h1A;  7'h03: seg_decode = 5'h1B;
            7'h46: seg_decode = 5'h1C;  7'h21: seg_decode = 5'h1D;
            7'h06: seg_decode = 5'h1E;  7'h0E: seg_decode = 5'h1F;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    assign w_same   = (ssd_dec_port_cc == r_cc) && (ssd_dec_port_an == r_an);
    // r_done keeps a held pair from being accepted twice
    assign w_accept = (r_cnt == STABLE_W) && !r_done;
    assign {w_seg_ok, w_nib} = seg_decode(r_cc);
    assign w_is_lo  = (r_an == 8'hFE);
    assign w_is_hi  = (r_an == 8'hFD);
    assign w_blank  = (r_an == 8'hFF);
    assign w_lo_ev  = w_accept && w_is_lo && w_seg_ok;
    assign w_hi_ev  = w_accept && w_is_hi && w_seg_ok;
    assign w_err_ev = w_accept && !w_blank && !((w_is_lo || w_is_hi) && w_seg_ok);

    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        w_byte     = {r_hi, r_lo};
        if (w_err_ev) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_lo_ev)      w_next = GOT_LO;
                    else if (w_hi_ev) w_next = GOT_HI;
                end
                GOT_LO: begin
                    if (w_hi_ev) begin
                        w_complete = 1'b1;
                        w_byte     = {w_nib, r_lo};
                        w_next     = IDLE;
                    end
                end
                GOT_HI: begin
                    if (w_lo_ev) begin
                        w_complete = 1'b1;
                        w_byte     = {r_hi, w_nib};
                        w_next     = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge ssd_clk) begin
        if (ssd_rst) begin
            r_state              <= IDLE;
            r_cc                 <= 7'h7F;
            r_an                 <= 8'hFF;
            r_cnt                <= 4'd0;
            r_done               <= 1'b0;
            r_lo                 <= 4'd0;
            r_hi                 <= 4'd0;
            ssd_dec_port_out     <= 8'h00;
            ssd_dec_port_valid   <= 1'b0;
            ssd_dec_port_chg     <= 1'b0;
            ssd_dec_port_err     <= 1'b0;
            ssd_dec_port_err_cnt <= 8'h00;
        end else begin
            r_state <= w_next;
            r_cc    <= ssd_dec_port_cc;
            r_an    <= ssd_dec_port_an;
            if (w_accept) r_done <= 1'b1;
            if (!w_same) begin
                r_cnt  <= 4'd1;
                r_done <= 1'b0;
            end else if (r_cnt != 4'hF) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_lo_ev) r_lo <= w_nib;
            if (w_hi_ev) r_hi <= w_nib;
            if (w_complete) ssd_dec_port_out <= w_byte;
            ssd_dec_port_valid <= w_complete;
            ssd_dec_port_chg   <= w_complete && (w_byte != ssd_dec_port_out);
            ssd_dec_port_err   <= w_err_ev;
            if (w_err_ev && ssd_dec_port_err_cnt != 8'hFF)
                ssd_dec_port_err_cnt <= ssd_dec_port_err_cnt + 8'd1;
        end
    end
endmodule
